// File: rtl/exhaustive_tt_checker.sv
// exhaustive_tt_checker: sweeps every input vector into a DUT and checks each response against a golden truth table.
module exhaustive_tt_checker #(
    parameter int N_IN = 3,
    parameter int N_OUT = 1,
    parameter logic [N_OUT*(2**N_IN)-1:0] GOLDEN = 8'h13,
    parameter int DUT_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop_on_fail,
    output logic [N_IN-1:0]      dut_in,
    input  logic [N_OUT-1:0]     dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic                 first_fail_valid,
    output logic [N_IN-1:0]      first_fail_vec,
    output logic [2**N_IN-1:0]   fail_map
);
    localparam int NV = 2**N_IN;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
    state_t state, next_state, entry;
    logic [N_IN:0] vec;
    logic [3:0] wait_cnt;
    logic stop_mode, mismatch, last_vec, halt, accept;
    logic [N_OUT-1:0] expected;
    assign dut_in = vec[N_IN-1:0];
    always_comb begin
        expected = GOLDEN[vec[N_IN-1:0]*N_OUT +: N_OUT];
        // identity compare so X/Z from the DUT is flagged as a mismatch in simulation
        mismatch = (state == SAMPLE) && (dut_out !== expected);
        last_vec = vec == (N_IN+1)'(NV-1);
        halt = last_vec || (stop_mode && mismatch);
        accept = start && (state == IDLE || state == DONE);
        entry = DUT_LAT == 0 ? SAMPLE : SETTLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= next_state;
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: next_state = start ? entry : state;
            SETTLE: next_state = wait_cnt == 4'(DUT_LAT-1) ? SAMPLE : SETTLE;
            SAMPLE: next_state = halt ? DONE : entry;
            default: next_state = IDLE;
        endcase
    end
    always_comb begin
        busy = state == SETTLE || state == SAMPLE;
        done = state == DONE;
        pass = done && err_count == '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec <= '0;
            wait_cnt <= '0;
            stop_mode <= 1'b0;
            err_count <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec <= '0;
            fail_map <= '0;
        end else if (accept) begin
            vec <= '0;
            wait_cnt <= '0;
            stop_mode <= stop_on_fail;
            err_count <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec <= '0;
            fail_map <= '0;
        end else if (state == SETTLE) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else if (state == SAMPLE) begin
            wait_cnt <= '0;
            if (mismatch) begin
                err_count <= err_count + 1'b1;
                fail_map[vec[N_IN-1:0]] <= 1'b1;
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_vec <= vec[N_IN-1:0];
                end
            end
            if (!halt) vec <= vec + 1'b1;
        end
    end
endmodule

// File: tb/tb_exhaustive_tt_checker.sv
// tb_exhaustive_tt_checker: drives truth-table DUT models into the checker and compares results to a population-count model.
module tb_exhaustive_tt_checker;
    localparam logic [7:0] GOLD = 8'h13;
    logic clk = 0, rst_n = 0, start = 0, stop_on_fail = 0, start_l = 0;
    logic [7:0] tt_r = GOLD;
    logic [2:0] dut_in, ff_vec;
    logic dut_out, busy, done, pass, ff_valid;
    logic [3:0] err_count;
    logic [7:0] fail_map;
    logic [2:0] in_l2, in_l0, ffv_l2, ffv_l0;
    logic r1_l2, r2_l2, r1_l0, r2_l0;
    logic busy_l2, done_l2, pass_l2, ffok_l2, busy_l0, done_l0, pass_l0, ffok_l0;
    logic [3:0] err_l2, err_l0;
    logic [7:0] map_l2, map_l0;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;
    assign dut_out = tt_r[dut_in];
    always @(posedge clk) begin
        r1_l2 <= GOLD[in_l2];
        r2_l2 <= r1_l2;
        r1_l0 <= GOLD[in_l0];
        r2_l0 <= r1_l0;
    end

    exhaustive_tt_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop_on_fail(stop_on_fail),
        .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail_valid(ff_valid), .first_fail_vec(ff_vec),
        .fail_map(fail_map));
    exhaustive_tt_checker #(.DUT_LAT(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .start(start_l), .stop_on_fail(1'b0),
        .dut_in(in_l2), .dut_out(r2_l2), .busy(busy_l2), .done(done_l2), .pass(pass_l2),
        .err_count(err_l2), .first_fail_valid(ffok_l2), .first_fail_vec(ffv_l2),
        .fail_map(map_l2));
    exhaustive_tt_checker #(.DUT_LAT(0)) u_l0 (
        .clk(clk), .rst_n(rst_n), .start(start_l), .stop_on_fail(1'b0),
        .dut_in(in_l0), .dut_out(r2_l0), .busy(busy_l0), .done(done_l0), .pass(pass_l0),
        .err_count(err_l0), .first_fail_valid(ffok_l0), .first_fail_vec(ffv_l0),
        .fail_map(map_l0));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_dut_in"}, dut_in, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err"}, err_count, 0);
        chk({tag, "_ffv"}, ff_valid, 0);
        chk({tag, "_ffvec"}, ff_vec, 0);
        chk({tag, "_map"}, fail_map, 0);
    endtask

    task automatic run(input logic [7:0] tt, input logic stop, input bit poke);
        logic [7:0] diff, exp_map;
        int first, exp_k, exp_err, k;
        diff = tt ^ GOLD;
        first = 0;
        for (int i = 7; i >= 0; i--) if (diff[i]) first = i;
        if (stop && diff != 0) begin
            exp_k = first + 1; exp_err = 1; exp_map = 8'd1 << first;
        end else begin
            exp_k = 8; exp_err = $countones(diff); exp_map = diff;
        end
        tt_r = tt;
        stop_on_fail = stop;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        stop_on_fail = !stop;
        chk("done_drop", done, 0);
        chk("err_clear", err_count, 0);
        chk("map_clear", fail_map, 0);
        chk("ffv_clear", ff_valid, 0);
        k = 0;
        while (!done && k < 64) begin
            chk("dut_in_seq", dut_in, k);
            chk("busy_sweep", busy, 1);
            if (poke && k == 2) start = 1;
            @(posedge clk); #1 start = 0;
            k++;
        end
        chk("done_cycle", k, exp_k);
        chk("busy_end", busy, 0);
        chk("err_count", err_count, exp_err);
        chk("fail_map", fail_map, exp_map);
        chk("ff_valid", ff_valid, diff != 0);
        chk("ff_vec", ff_vec, diff != 0 ? first : 0);
        chk("pass", pass, diff == 0);
        chk("dut_in_hold", dut_in, exp_k - 1);
    endtask

    initial begin
        #12;
        check_idle_outputs("reset");
        @(posedge clk); #1 rst_n = 1;
        run(GOLD, 0, 0);
        run(8'h31, 0, 0);
        run(8'h31, 1, 0);
        run(GOLD, 0, 1);
        run(8'h31, 0, 0);
        run(8'h31, 0, 0);
        tt_r = 8'h31;
        stop_on_fail = 0;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        repeat (4) @(posedge clk);
        #3 rst_n = 0;
        #1 check_idle_outputs("abort");
        @(posedge clk); #1 rst_n = 1;
        run(GOLD, 0, 0);
        repeat (8) run(8'($urandom), 1'($urandom_range(0, 1)), 0);
        begin
            int k;
            @(posedge clk); #1 start_l = 1;
            @(posedge clk); #1 start_l = 0;
            k = 0;
            while (!done_l2 && k < 200) begin
                chk("lat_dut_in", in_l2, k / 3);
                @(posedge clk); #1;
                k++;
            end
            chk("lat_done_cycle", k, 24);
            chk("lat_pass", pass_l2, 1);
            chk("lat0_done", done_l0, 1);
            chk("lat0_err_nonzero", err_l0 != 0, 1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/exhaustive_tt_checker.md
Name: exhaustive_tt_checker

Overview:
- Self-checking stimulus engine for small combinational or shallow-pipelined logic blocks under test (DUT).
- Sweeps all 2^N_IN input vectors into the DUT and compares each DUT response against a golden truth table given as a parameter.
- Reports error count, the first failing vector, and a per-vector fail bitmap.
- Generalises fixed 3-input, 1-output bench checks to any input/output width, DUT latency, and an optional stop-on-first-fail mode.

Parameters:
- N_IN, 3, number of DUT inputs (1..8).
- N_OUT, 1, number of DUT outputs (1..8).
- GOLDEN, 8'h13, expected outputs, N_OUT*2^N_IN bits. Vector v's expected output is GOLDEN[v*N_OUT +: N_OUT].
- DUT_LAT, 0, cycles from dut_in change to a valid dut_out (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a sweep when not busy.
- stop_on_fail  in  1  mode select, sampled with start. 1 = halt after the first mismatch.
- dut_in  out  N_IN  stimulus vector driven to the DUT.
- dut_out  in  N_OUT  DUT response.
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; level, held until the next accepted start.
- pass  out  1  done && err_count==0.
- err_count  out  N_IN+1  number of mismatching vectors.
- first_fail_valid  out  1  at least one mismatch recorded.
- first_fail_vec  out  N_IN  lowest-indexed failing vector.
- fail_map  out  2^N_IN  bit v set if vector v mismatched.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, including dut_in. FSM goes to IDLE and the internal counters clear. Reset mid-sweep aborts immediately; no partial results are retained.
- FSM states are IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 at edge t gives:
  - results cleared;
  - stop mode latched;
  - vec=0, dut_in=0;
  - next state SETTLE, or SAMPLE if DUT_LAT=0;
  - busy=1.
- SETTLE: hold dut_in for DUT_LAT cycles using a wait counter, then go to SAMPLE.
- SAMPLE (one cycle): compare dut_out with the golden slice for vec, combinationally in this cycle. On mismatch:
  - err_count increments;
  - fail_map[vec] is set;
  - if first_fail_valid is 0, first_fail_vec=vec and first_fail_valid=1.
- After the compare:
  - If vec == 2^N_IN-1, or (stop mode && mismatch), go to DONE.
  - Otherwise vec increments, dut_in takes the new vec, and the FSM returns to SETTLE (or SAMPLE if DUT_LAT=0).
- Timing: each vector occupies exactly DUT_LAT+1 cycles with dut_in stable. For a full sweep, done rises at edge t + 2^N_IN*(DUT_LAT+1), and busy falls on the same edge.
- DONE: done=1 and busy=0. dut_in holds the last vector. Results are frozen.
  - start in DONE clears results and restarts exactly as from IDLE; done drops on that edge.
- start while busy is ignored, and the sweep continues unaffected.
- Compare is exact bitwise equality. X/Z on dut_out counts as a mismatch, so the compare uses identity semantics in simulation.
- err_count width N_IN+1 cannot saturate, because max = 2^N_IN.
- vec counter width N_IN+1 prevents wrap-around ambiguity at the last vector.
- stop_on_fail is ignored after start; toggling it mid-sweep has no effect.

Test Plan:
1. Defaults, DUT = correct intended function (truth table 8'h13), start at edge t → busy for 8 cycles, dut_in sequence 0..7, done at t+8, err_count=0, pass=1, fail_map=0, first_fail_valid=0.
2. Defaults, DUT y=(~b&~c)|(a&~b), stop_on_fail=0 → err_count=2, fail_map=8'b0010_0010, first_fail_vec=3'b001, first_fail_valid=1, pass=0, done at t+8.
3. Same DUT, stop_on_fail=1 → halts after vector 1, done at t+2, err_count=1, fail_map=8'b0000_0010, dut_in holds 3'b001.
4. DUT_LAT=2, DUT = correct function registered twice → each dut_in value held 3 cycles, done at t+24, pass=1. Same DUT with DUT_LAT=0 → err_count>0.
5. rst_n low at cycle t+4 of a sweep → all outputs 0 asynchronously, FSM IDLE. A new start gives a full clean sweep: done at +8, correct results.
6. start pulsed at t+3 mid-sweep → ignored, done still at t+8. start pulsed in DONE → done drops, results clear, a second sweep completes with identical results.
